dtw_backtrace: RTL and testbench

// - Reader/consumer of the systolic-array output side: captures per-cell warp-direction codes (o_path) with their
//   (t,r) indices from dtw_dc, then walks the stored direction map from (tlen,rlen) back to (0,0).
// - Emits the optimal warping path as a valid/ready stream of (t,r) pairs for the downstream alignment logic.

---
 rtl/dtw_pkg.sv | 34 +++
 rtl/dtw_path_map.sv | 55 +++++
 rtl/dtw_backtrace.sv | 149 ++++++++++++++
 tb/tb_dtw_backtrace.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// ---------------------------------------------------------------------------
// dtw_pkg
// Shared constants and types for the DTW backtrace block.
//   LANES  : PE lanes delivered per cycle (lane 0 in the MS slice of buses)
//   IDXW   : index width; the direction map is 2^IDXW x 2^IDXW cells
//   DIRW   : direction code width
//   dir_t  : warp-direction codes stored per cell
//   state_t: backtrace FSM states
// ---------------------------------------------------------------------------
package dtw_pkg;

  localparam int LANES = 6;
  localparam int IDXW  = 5;
  localparam int DIRW  = 2;
  localparam int MAP_N = 1 << IDXW;
  localparam int STEPW = 6;

  localparam logic [IDXW-1:0]  IDX_ONE  = IDXW'(1);
  localparam logic [STEPW-1:0] STEP_ONE = STEPW'(1);

  typedef enum logic [DIRW-1:0] {
    DIR_DIAG = 2'd0,  // predecessor (t-1, r-1)
    DIR_UP   = 2'd1,  // predecessor (t-1, r)
    DIR_LEFT = 2'd2,  // predecessor (t, r-1)
    DIR_INV  = 2'd3   // cell never written
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dtw_path_map.sv
// ---------------------------------------------------------------------------
// dtw_path_map
// 2^IDXW x 2^IDXW array of direction codes written by the systolic array and
// read back by the backtrace walker.
//   clk, nrst   : clock, asynchronous active-low reset (map -> DIR_INV)
//   i_we        : global write qualifier (only IDLE with ena high)
//   i_tindex    : per-lane t index, lane k at [(LANES-1-k)*IDXW +: IDXW]
//   i_rindex    : per-lane r index, same packing
//   i_path      : per-lane code,    lane k at [(LANES-1-k)*DIRW +: DIRW]
//   i_lvld      : per-lane write enable, lane k at bit LANES-1-k
//   i_rd_t/r    : asynchronous read address
//   o_code      : code stored at (i_rd_t, i_rd_r)
// ---------------------------------------------------------------------------
module dtw_path_map
  import dtw_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_we,
  input  logic [LANES*IDXW-1:0] i_tindex,
  input  logic [LANES*IDXW-1:0] i_rindex,
  input  logic [LANES*DIRW-1:0] i_path,
  input  logic [LANES-1:0]      i_lvld,
  input  logic [IDXW-1:0]       i_rd_t,
  input  logic [IDXW-1:0]       i_rd_r,
  output logic [DIRW-1:0]       o_code
);

  logic [DIRW-1:0] r_map [MAP_N][MAP_N];

  // NOTE: the map is built from flops rather than a RAM macro, so it can and
  // must be reset: an unwritten cell has to read back as DIR_INV.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int t = 0; t < MAP_N; t++) begin
        for (int r = 0; r < MAP_N; r++) begin
          r_map[t][r] <= DIR_INV;
        end
      end
    end else if (i_we) begin
      // Lanes are visited in ascending order; a later non-blocking write to
      // the same cell overrides an earlier one, so the higher lane wins.
      for (int k = 0; k < LANES; k++) begin
        if (i_lvld[LANES-1-k]) begin
          r_map[i_tindex[(LANES-1-k)*IDXW +: IDXW]]
               [i_rindex[(LANES-1-k)*IDXW +: IDXW]]
            <= i_path[(LANES-1-k)*DIRW +: DIRW];
        end
      end
    end
  end

  assign o_code = r_map[i_rd_t][i_rd_r];

endmodule

// File: rtl/dtw_backtrace.sv
// ---------------------------------------------------------------------------
// dtw_backtrace
// Captures per-cell warp directions from the systolic array, then walks the
// map from (tlen, rlen) back to (0,0), streaming (t,r) pairs downstream.
//   clk, nrst          : clock, asynchronous active-low reset
//   ena                : block enable; low aborts to IDLE on the next edge
//   i_tindex/i_rindex  : per-lane cell indices (lane 0 in the MS slice)
//   i_path, i_lvld     : per-lane direction code and write enable
//   i_tlen, i_rlen     : trace start point, latched on accepted i_start
//   i_start            : trace request, honoured in IDLE only
//   i_ready            : downstream ready
//   o_t, o_r, o_valid  : path pair stream
//   o_last             : pair is (0,0) or the pair that hit an INVALID code
//   o_busy, o_done     : tracing / one-cycle end-of-trace pulse
//   o_err              : sticky INVALID-code flag, cleared by next i_start
// Optional feature macro DTW_BT_STEPS_EN adds o_steps, the number of pairs
// accepted in the current trace.
// ---------------------------------------------------------------------------
module dtw_backtrace
  import dtw_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  ena,
  input  logic [LANES*IDXW-1:0] i_tindex,
  input  logic [LANES*IDXW-1:0] i_rindex,
  input  logic [LANES*DIRW-1:0] i_path,
  input  logic [LANES-1:0]      i_lvld,
  input  logic [IDXW-1:0]       i_tlen,
  input  logic [IDXW-1:0]       i_rlen,
  input  logic                  i_start,
  input  logic                  i_ready,
  output logic [IDXW-1:0]       o_t,
  output logic [IDXW-1:0]       o_r,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
`ifdef DTW_BT_STEPS_EN
  output logic [STEPW-1:0]      o_steps,
`endif
  output logic                  o_err
);

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_t, r_r, w_t_nxt, w_r_nxt;
  logic            r_err;
  logic [DIRW-1:0] w_code;
  logic            w_we, w_start, w_fire;
  logic            w_origin, w_interior, w_bad;

  assign w_we       = (r_state == ST_IDLE) && ena;
  assign w_start    = w_we && i_start;
  assign w_fire     = (r_state == ST_TRACE) && ena && i_ready;
  assign w_origin   = (r_t == '0) && (r_r == '0);
  // Border cells step along the edge regardless of their stored code.
  assign w_interior = (r_t != '0) && (r_r != '0);
  assign w_bad      = w_interior && (w_code == DIR_INV);

  dtw_path_map u_map (
    .clk      (clk),
    .nrst     (nrst),
    .i_we     (w_we),
    .i_tindex (i_tindex),
    .i_rindex (i_rindex),
    .i_path   (i_path),
    .i_lvld   (i_lvld),
    .i_rd_t   (r_t),
    .i_rd_r   (r_r),
    .o_code   (w_code)
  );

  // NOTE: combinational blocks assign every output a default first so that
  // no path leaves a value unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_TRACE;
      ST_TRACE: if (i_ready && (w_origin || w_bad)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (!ena) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    w_t_nxt = r_t;
    w_r_nxt = r_r;
    if (w_start) begin
      w_t_nxt = i_tlen;
      w_r_nxt = i_rlen;
    end else if (w_fire && !w_origin && !w_bad) begin
      if (r_t == '0) begin
        w_r_nxt = r_r - IDX_ONE;
      end else if (r_r == '0) begin
        w_t_nxt = r_t - IDX_ONE;
      end else begin
        unique case (w_code)
          DIR_DIAG: begin
            w_t_nxt = r_t - IDX_ONE;
            w_r_nxt = r_r - IDX_ONE;
          end
          DIR_UP:   w_t_nxt = r_t - IDX_ONE;
          DIR_LEFT: w_r_nxt = r_r - IDX_ONE;
          default:  ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_r     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_r     <= w_r_nxt;
      if (w_start)               r_err <= 1'b0;
      else if (w_fire && w_bad)  r_err <= 1'b1;
    end
  end

`ifdef DTW_BT_STEPS_EN
  logic [STEPW-1:0] r_steps;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        r_steps <= '0;
    else if (w_start) r_steps <= '0;
    else if (w_fire)  r_steps <= r_steps + STEP_ONE;
  end

  assign o_steps = r_steps;
`endif

  assign o_t     = r_t;
  assign o_r     = r_r;
  assign o_valid = (r_state == ST_TRACE);
  assign o_busy  = (r_state == ST_TRACE);
  assign o_done  = (r_state == ST_DONE);
  // Gated by TRACE so the idle (0,0) start-up cursor does not flag last.
  assign o_last  = (r_state == ST_TRACE) && (w_origin || w_bad);
  assign o_err   = r_err;

endmodule

// File: tb/tb_dtw_backtrace.sv
// ---------------------------------------------------------------------------
// tb_dtw_backtrace
// Directed bench for dtw_backtrace. Expected (t,r,last) pairs are queued as
// each trace is requested and popped as the DUT hands them off.
// Define DTW_BT_STEPS_EN to also check o_steps.
// ---------------------------------------------------------------------------
module tb_dtw_backtrace;
  import dtw_pkg::*;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  ena;
  logic [LANES*IDXW-1:0] i_tindex;
  logic [LANES*IDXW-1:0] i_rindex;
  logic [LANES*DIRW-1:0] i_path;
  logic [LANES-1:0]      i_lvld;
  logic [IDXW-1:0]       i_tlen, i_rlen;
  logic                  i_start, i_ready;
  logic [IDXW-1:0]       o_t, o_r;
  logic                  o_valid, o_last, o_busy, o_done, o_err;
`ifdef DTW_BT_STEPS_EN
  logic [STEPW-1:0]      o_steps;
`endif

  dtw_backtrace dut (
    .clk      (clk),
    .nrst     (nrst),
    .ena      (ena),
    .i_tindex (i_tindex),
    .i_rindex (i_rindex),
    .i_path   (i_path),
    .i_lvld   (i_lvld),
    .i_tlen   (i_tlen),
    .i_rlen   (i_rlen),
    .i_start  (i_start),
    .i_ready  (i_ready),
    .o_t      (o_t),
    .o_r      (o_r),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .o_busy   (o_busy),
    .o_done   (o_done),
`ifdef DTW_BT_STEPS_EN
    .o_steps  (o_steps),
`endif
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDXW-1:0] t;
    logic [IDXW-1:0] r;
    logic            last;
  } pair_t;

  pair_t q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [IDXW-1:0] t, input logic [IDXW-1:0] r, input logic last);
    pair_t p;
    p.t = t; p.r = r; p.last = last;
    q.push_back(p);
  endtask

  // Load one lane's fields; caller is positioned at a negedge.
  task automatic set_lane(input int k, input logic [IDXW-1:0] t, input logic [IDXW-1:0] r,
                          input logic [DIRW-1:0] code);
    i_tindex[(LANES-1-k)*IDXW +: IDXW] = t;
    i_rindex[(LANES-1-k)*IDXW +: IDXW] = r;
    i_path[(LANES-1-k)*DIRW +: DIRW]   = code;
    i_lvld[LANES-1-k]                  = 1'b1;
  endtask

  task automatic commit_writes();
    @(negedge clk);
    i_lvld = '0;
  endtask

  // Request a trace and consume pairs until o_done, comparing each offered
  // pair against the queue head. Optionally hold i_ready low for stall_len
  // cycles while the pair with index stall_idx is offered.
  task automatic run_trace(input logic [IDXW-1:0] tl, input logic [IDXW-1:0] rl,
                           input int stall_idx, input int stall_len, input logic exp_err,
                           input string tag);
    int    popped = 0;
    int    stall  = stall_len;
    int    last_c = -10;
    int    done_c = -1;
    pair_t e;
    @(negedge clk);
    i_tlen  = tl;
    i_rlen  = rl;
    i_start = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_busy"}, o_busy, 1);
    for (int c = 0; c < 200; c++) begin
      if (o_done) begin
        done_c = c;
        break;
      end
      if (o_valid) begin
        if (q.size() == 0) begin
          check({tag, "_extra_pair"}, q.size(), 1);
          break;
        end
        e = q[0];
        check({tag, "_t"},    o_t,    e.t);
        check({tag, "_r"},    o_r,    e.r);
        check({tag, "_last"}, o_last, e.last);
        if (popped == stall_idx && stall > 0) begin
          i_ready = 1'b0;
          stall--;
        end else begin
          i_ready = 1'b1;
          void'(q.pop_front());
          popped++;
          if (e.last) last_c = c;
        end
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, (done_c >= 0), 1);
    check({tag, "_done_latency"}, done_c - last_c, 1);
    check({tag, "_done_valid"}, o_valid, 0);
    check({tag, "_queue_empty"}, q.size(), 0);
    check({tag, "_err"}, o_err, exp_err);
`ifdef DTW_BT_STEPS_EN
    check({tag, "_steps"}, o_steps, popped);
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, o_done, 0);
    check({tag, "_idle_busy"}, o_busy, 0);
    check({tag, "_err_sticky"}, o_err, exp_err);
    q.delete();
  endtask

  initial begin
    nrst     = 1'b0;
    ena      = 1'b0;
    i_tindex = '0;
    i_rindex = '0;
    i_path   = '0;
    i_lvld   = '0;
    i_tlen   = '0;
    i_rlen   = '0;
    i_start  = 1'b0;
    i_ready  = 1'b0;
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_busy",  o_busy,  0);
    check("rst_done",  o_done,  0);
    check("rst_err",   o_err,   0);
    check("rst_last",  o_last,  0);
    check("rst_t",     o_t,     0);
    check("rst_r",     o_r,     0);
    @(negedge clk);
    nrst = 1'b1;
    ena  = 1'b1;

    // Diagonal 0..3 = DIAG, uninterrupted trace.
    @(negedge clk);
    set_lane(0, 0, 0, DIR_DIAG);
    set_lane(1, 1, 1, DIR_DIAG);
    set_lane(2, 2, 2, DIR_DIAG);
    set_lane(3, 3, 3, DIR_DIAG);
    commit_writes();
    push(3, 3, 0); push(2, 2, 0); push(1, 1, 0); push(0, 0, 1);
    run_trace(3, 3, -1, 0, 1'b0, "diag");

    // Same map, backpressure for 3 cycles while (2,2) is offered.
    push(3, 3, 0); push(2, 2, 0); push(1, 1, 0); push(0, 0, 1);
    run_trace(3, 3, 1, 3, 1'b0, "stall");

    // Border walk over unwritten cells.
    push(2, 0, 0); push(1, 0, 0); push(0, 0, 1);
    run_trace(2, 0, -1, 0, 1'b0, "border");

    // Capture attempt during TRACE must be ignored; abort after 2nd pair.
    @(negedge clk);
    i_tlen  = 3;
    i_rlen  = 3;
    i_start = 1'b1;
    i_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    check("abort_p0_t", o_t, 3);
    check("abort_p0_valid", o_valid, 1);
    set_lane(0, 2, 2, DIR_UP);
    i_ready = 1'b1;
    @(negedge clk);
    i_lvld = '0;
    check("abort_p1_t", o_t, 2);
    check("abort_p1_r", o_r, 2);
    @(negedge clk);
    check("abort_p2_t", o_t, 1);
    ena = 1'b0;
    @(negedge clk);
    check("abort_valid", o_valid, 0);
    check("abort_busy",  o_busy,  0);
    check("abort_done",  o_done,  0);
    ena = 1'b1;
    push(3, 3, 0); push(2, 2, 0); push(1, 1, 0); push(0, 0, 1);
    run_trace(3, 3, -1, 0, 1'b0, "restart");

    // Reset in the middle of a trace; also re-initialises the map.
    @(negedge clk);
    i_tlen  = 3;
    i_rlen  = 3;
    i_start = 1'b1;
    i_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    check("mid_rst_pre_valid", o_valid, 1);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_busy",  o_busy,  0);
    check("mid_rst_t",     o_t,     0);
    @(negedge clk);
    nrst = 1'b1;

    // UP then LEFT into an unwritten interior cell.
    @(negedge clk);
    set_lane(0, 3, 3, DIR_UP);
    set_lane(1, 2, 3, DIR_LEFT);
    commit_writes();
    push(3, 3, 0); push(2, 3, 0); push(2, 2, 1);
    run_trace(3, 3, -1, 0, 1'b1, "invalid");

    // Same-cell write from lanes 0 and 4: lane 4 (LEFT) must win.
    @(negedge clk);
    set_lane(0, 1, 1, DIR_DIAG);
    set_lane(4, 1, 1, DIR_LEFT);
    commit_writes();
    push(1, 1, 0); push(1, 0, 0); push(0, 0, 1);
    run_trace(1, 1, -1, 0, 1'b0, "lane_prio");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
